// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request and response channels, 64-bit words, byte-masked stores.
// Optional DMEM_RAND_DELAY_EN adds 0..3 pseudo-random wait cycles per transaction from an 8-bit LFSR.
module dmem_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_wen,
    input  logic [63:0]           req_wdata,
    input  logic [7:0]            req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [63:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef DMEM_RAND_DELAY_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_BASE = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wen;
    logic [63:0]           r_wdata;
    logic [7:0]            r_wmask;
    logic                  r_rsp_valid;
    logic [63:0]           r_rsp_rdata;
    logic                  r_rsp_err;
    logic [63:0]           r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_offset;
    logic [ADDR_WIDTH-1:0] w_index;
    logic [IDX_W-1:0]      w_word_idx;
    logic                  w_oor;
    logic                  w_commit;
    logic [CNT_W-1:0]      w_cnt_load;

    // Index arithmetic wraps in ADDR_WIDTH bits; addresses below the base are caught separately.
    assign w_offset   = r_addr - BASE_ADDR;
    assign w_index    = w_offset >> 3;
    assign w_word_idx = w_index[IDX_W-1:0];
    assign w_oor      = (r_addr < BASE_ADDR) || (w_index >= DEPTH_A);
    assign w_commit   = (r_state == S_WAIT) && (r_cnt == '0);

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

`ifdef DMEM_RAND_DELAY_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_cnt_load = CNT_BASE + {{(CNT_W-2){1'b0}}, r_lfsr[1:0]};

    // Fibonacci LFSR (taps 8,6,5,4) free-running on every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= 8'h5A;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end
`else
    assign w_cnt_load = CNT_BASE;
`endif

    // Transaction sequencer: accept, count down, perform access, hold response until handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_wdata     <= 64'd0;
            r_wmask     <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 64'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wen   <= req_wen;
                        r_wdata <= req_wdata;
                        r_wmask <= req_wmask;
                        r_cnt   <= w_cnt_load;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_oor;
                        r_rsp_rdata <= (!w_oor && !r_wen) ? r_mem[w_word_idx] : 64'd0;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 64'd0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; a store commits only on the WAIT->RESP edge.
    always_ff @(posedge clk) begin
        if (w_commit && r_wen && !w_oor) begin
            for (int i = 0; i < 8; i++) begin
                if (r_wmask[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level memory model.
module tb_dmem_responder;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        req_wen = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_wmask = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .ADDR_WIDTH(32),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_wen  (req_wen),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: memory contents with per-byte "known" flags.
    logic [63:0] mem_model [int];
    logic [7:0]  mem_known [int];
    bit          m_out = 1'b0;
    int          m_age = 0;
    int          m_lat = LAT;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [63:0] m_wdata;
    logic [7:0]  m_wmask;
    logic        m_err = 1'b0;
    logic [63:0] m_rdata = 64'd0;
    logic [63:0] m_cmp_mask = 64'd0;
    logic [7:0]  m_lfsr = 8'h5A;

    task automatic model_commit();
        logic [31:0] off;
        int          idx;
        off   = m_addr - BASE;
        idx   = int'(off >> 3);
        m_err = (m_addr < BASE) || ((off >> 3) >= 32'(DEPTH));
        m_rdata    = 64'd0;
        m_cmp_mask = {64{1'b1}};
        if (!m_err && m_wen) begin
            if (!mem_model.exists(idx)) begin
                mem_model[idx] = 64'd0;
                mem_known[idx] = 8'd0;
            end
            for (int b = 0; b < 8; b++) begin
                if (m_wmask[b]) begin
                    mem_model[idx][8*b +: 8] = m_wdata[8*b +: 8];
                    mem_known[idx][b] = 1'b1;
                end
            end
        end else if (!m_err) begin
            if (mem_model.exists(idx)) begin
                m_rdata = mem_model[idx];
                for (int b = 0; b < 8; b++) m_cmp_mask[8*b +: 8] = {8{mem_known[idx][b]}};
            end else begin
                m_cmp_mask = 64'd0;
            end
        end
    endtask

    // Model update on each rising edge from the bench's own driven inputs.
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            m_out  = 1'b0;
            m_lfsr = 8'h5A;
        end else begin
            if (!m_out) begin
                if (req_valid) begin
                    m_addr  = req_addr;
                    m_wen   = req_wen;
                    m_wdata = req_wdata;
                    m_wmask = req_wmask;
                    m_age   = 0;
                    m_out   = 1'b1;
`ifdef DMEM_RAND_DELAY_EN
                    m_lat   = LAT + int'(m_lfsr[1:0]);
`else
                    m_lat   = LAT;
`endif
                end
            end else if (m_age >= m_lat) begin
                if (rsp_ready) m_out = 1'b0;
            end else begin
                m_age++;
                if (m_age == m_lat) model_commit();
            end
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    // Per-cycle comparison of all outputs against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!rst || !m_out) begin
            chk("idle_ready", req_ready, 1);
            chk("idle_valid", rsp_valid, 0);
            chk("idle_rdata", rsp_rdata, 0);
            chk("idle_err",   rsp_err,   0);
        end else if (m_age < m_lat) begin
            chk("wait_ready", req_ready, 0);
            chk("wait_valid", rsp_valid, 0);
            chk("wait_err",   rsp_err,   0);
        end else begin
            chk("resp_ready", req_ready, 0);
            chk("resp_valid", rsp_valid, 1);
            chk("resp_err",   rsp_err,   m_err);
            chk("resp_rdata", rsp_rdata & m_cmp_mask, m_rdata & m_cmp_mask);
        end
    end

    task automatic do_txn(input logic [31:0] a, input logic w, input logic [63:0] d,
                          input logic [7:0] m, input int hold,
                          output logic [63:0] rd, output logic er, output int lat);
        int          n;
        logic [63:0] first_rd;
        req_addr  = a;
        req_wen   = w;
        req_wdata = d;
        req_wmask = m;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL accept_timeout: req_ready never rose for addr %h", a);
        end
        @(posedge clk); #2;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wen   = 1'($urandom);
        req_wdata = {$urandom, $urandom};
        req_wmask = 8'($urandom);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #2;
            lat++;
        end
        if (lat >= 40) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid never rose for addr %h", a);
        end
        first_rd = rsp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #2;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, first_rd);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #2;
        rsp_ready = 1'($urandom);
    endtask

    task automatic chk_lat(input int lat);
`ifdef DMEM_RAND_DELAY_EN
        chk("latency_range", (lat >= LAT && lat <= LAT + 3), 1);
`else
        chk("latency", lat, LAT);
`endif
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = BASE + 32'h1FF8;
            1:       a = BASE + 32'h2000 + 32'($urandom_range(0, 64) * 8);
            2:       a = BASE - 32'($urandom_range(1, 64) * 8);
            3:       a = $urandom;
            default: a = BASE + 32'($urandom_range(0, 15) * 8);
        endcase
        a[2:0] = 3'($urandom);
        return a;
    endfunction

    logic [63:0] rd;
    logic        er;
    int          lat;

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err",   rsp_err,   0);
        @(posedge clk); #2;

        do_txn(32'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 0, rd, er, lat);
        chk_lat(lat);
        chk("st_err", er, 0);
        chk("st_rdata", rd, 64'd0);
        do_txn(32'h8000_0010, 1'b0, 64'd0, 8'h00, 0, rd, er, lat);
        chk_lat(lat);
        chk("ld_rdata", rd, 64'h1122_3344_5566_7788);

        do_txn(32'h8000_0010, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, rd, er, lat);
        do_txn(32'h8000_0010, 1'b0, 64'd0, 8'hFF, 0, rd, er, lat);
        chk("mask_rdata", rd, 64'h1122_3344_AAAA_AAAA);

        do_txn(32'h8000_0010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, rd, er, lat);
        chk("nomask_err", er, 0);
        do_txn(32'h8000_0010, 1'b0, 64'd0, 8'h00, 5, rd, er, lat);
        chk("bp_rdata", rd, 64'h1122_3344_AAAA_AAAA);
        chk("bp_ready_after", req_ready, 1);

        do_txn(32'h8000_0000, 1'b1, 64'h0BAD_F00D_0BAD_F00D, 8'hFF, 0, rd, er, lat);
        do_txn(32'h8000_1FF8, 1'b1, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 0, rd, er, lat);
        chk("top_st_err", er, 0);
        do_txn(32'h7FFF_FFF8, 1'b0, 64'd0, 8'hFF, 0, rd, er, lat);
        chk("low_err", er, 1);
        chk("low_rdata", rd, 64'd0);
        do_txn(32'h8000_2000, 1'b1, 64'h5555_5555_5555_5555, 8'hFF, 0, rd, er, lat);
        chk("high_err", er, 1);
        chk("high_rdata", rd, 64'd0);
        do_txn(32'h8000_1FF8, 1'b0, 64'd0, 8'hFF, 0, rd, er, lat);
        chk("top_ld_err", er, 0);
        chk("top_ld_rdata", rd, 64'h0F0E_0D0C_0B0A_0908);
        do_txn(32'h8000_0000, 1'b0, 64'd0, 8'hFF, 0, rd, er, lat);
        chk("nowrap_rdata", rd, 64'h0BAD_F00D_0BAD_F00D);

        // Reset one cycle after accept, before the commit edge: the store must be lost.
        do_txn(32'h8000_0020, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, rd, er, lat);
        req_addr  = 32'h8000_0020;
        req_wen   = 1'b1;
        req_wdata = 64'h0000_0000_0000_DEAD;
        req_wmask = 8'hFF;
        req_valid = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        do_txn(32'h8000_0020, 1'b0, 64'd0, 8'hFF, 0, rd, er, lat);
        chk("midrst_rdata", rd, 64'h0123_4567_89AB_CDEF);

        for (int t = 0; t < 250; t++) begin
            do_txn(rand_addr(), 1'($urandom), {$urandom, $urandom}, 8'($urandom),
                   $urandom_range(0, 3), rd, er, lat);
            chk_lat(lat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #2;
            end
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
